// File: rtl/y_byte_stuffer.sv
// JPEG Y-channel byte stuffer: 4-entry word FIFO feeding an MSB-first byte emitter with 0xFF->0x00 stuffing.
// Optional macro BYTE_STUFF_EOI_EN appends the EOI marker (0xFF 0xD9) after the image's last word.
module y_byte_stuffer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] JPEG_bitstream,
    input  logic        data_ready,
    input  logic        eof_in,
    input  logic [4:0]  eof_bits,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        fifo_full,
    output logic        overflow,
    output logic        eoi_done
);

`ifdef BYTE_STUFF_EOI_EN
    localparam logic EOI_EN = 1'b1;
`else
    localparam logic EOI_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EMIT  = 3'd1,
        STUFF = 3'd2,
        EOI1  = 3'd3,
        EOI2  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] fifo_word_q [4];
    logic [31:0] fifo_word_d [4];
    logic [2:0]  fifo_cnt_q  [4];
    logic [2:0]  fifo_cnt_d  [4];
    logic        fifo_last_q [4];
    logic        fifo_last_d [4];
    logic [31:0] shift_q, shift_d;
    logic [2:0]  left_q, left_d;
    logic        last_q, last_d;
    logic        overflow_q, overflow_d;
    logic        eoi_done_q, eoi_done_d;

    logic        pop;
    logic        finish;
    logic        wr_en;
    logic [31:0] in_word;
    logic [2:0]  in_cnt;

    assign fifo_full = (count_q == 3'd4);
    assign overflow  = overflow_q;
    assign eoi_done  = eoi_done_q;

    // Last word: keep the top eof_bits bits, pad the rest with ones; byte count rounds up.
    always_comb begin
        in_word = JPEG_bitstream;
        in_cnt  = 3'd4;
        if (eof_in && (eof_bits != 5'd0)) begin
            in_word = JPEG_bitstream | (32'hFFFF_FFFF >> eof_bits);
            in_cnt  = {1'b0, eof_bits[4:3]} + {2'b00, |eof_bits[2:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        left_d     = left_q;
        last_d     = last_q;
        pop        = 1'b0;
        finish     = 1'b0;
        eoi_done_d = 1'b0;
        byte_out   = 8'h00;
        byte_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != 3'd0) pop = 1'b1;
            end
            EMIT: begin
                byte_valid = 1'b1;
                byte_out   = shift_q[31:24];
                if (byte_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    left_d  = left_q - 3'd1;
                    if (shift_q[31:24] == 8'hFF) state_d = STUFF;
                    else if (left_q == 3'd1)     finish  = 1'b1;
                end
            end
            STUFF: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    if (left_q == 3'd0) finish  = 1'b1;
                    else                state_d = EMIT;
                end
            end
            EOI1: begin
                byte_valid = 1'b1;
                byte_out   = 8'hFF;
                if (byte_ready) state_d = EOI2;
            end
            EOI2: begin
                byte_valid = 1'b1;
                byte_out   = 8'hD9;
                if (byte_ready) begin
                    eoi_done_d = 1'b1;
                    if (count_q != 3'd0) pop     = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry exhausted: marker, back-to-back pop of the next entry, or idle.
        if (finish) begin
            if (last_q && EOI_EN) begin
                state_d = EOI1;
            end else begin
                eoi_done_d = last_q;
                if (count_q != 3'd0) pop     = 1'b1;
                else                 state_d = IDLE;
            end
        end

        if (pop) begin
            shift_d = fifo_word_q[rd_ptr_q];
            left_d  = fifo_cnt_q[rd_ptr_q];
            last_d  = fifo_last_q[rd_ptr_q];
            state_d = EMIT;
        end
    end

    always_comb begin
        fifo_word_d = fifo_word_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_last_d = fifo_last_q;
        wr_en       = data_ready && (!fifo_full || pop);
        overflow_d  = overflow_q | (data_ready && fifo_full && !pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_en) begin
            fifo_word_d[wr_ptr_q] = in_word;
            fifo_cnt_d[wr_ptr_q]  = in_cnt;
            fifo_last_d[wr_ptr_q] = eof_in;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        count_d = count_q + {2'b00, wr_en} - {2'b00, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            shift_q    <= 32'd0;
            left_q     <= 3'd0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            eoi_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_word_q[i] <= 32'd0;
                fifo_cnt_q[i]  <= 3'd0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            eoi_done_q  <= eoi_done_d;
            fifo_word_q <= fifo_word_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_last_q <= fifo_last_d;
        end
    end

endmodule

// File: tb/tb_y_byte_stuffer.sv
// Scoreboard bench for y_byte_stuffer: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_y_byte_stuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] JPEG_bitstream;
    logic        data_ready;
    logic        eof_in;
    logic [4:0]  eof_bits;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        fifo_full;
    logic        overflow;
    logic        eoi_done;

    logic tb_ready;
    logic rnd_ready;
    logic rnd_mode;
    assign byte_ready = rnd_mode ? rnd_ready : tb_ready;

    y_byte_stuffer dut (
        .clk(clk), .rst(rst), .JPEG_bitstream(JPEG_bitstream), .data_ready(data_ready),
        .eof_in(eof_in), .eof_bits(eof_bits), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .fifo_full(fifo_full), .overflow(overflow), .eoi_done(eoi_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         fin;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   acc_cnt = 0;
    bit   eoi_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Reference: bytes of the (padded) word MSB-first, each 0xFF followed by 0x00, optional EOI marker.
    task automatic push_model(input logic [31:0] w, input bit last, input logic [4:0] eb);
        logic [31:0] v;
        logic [31:0] ones;
        int          n;
        exp_t        e;
        v = w;
        n = 4;
        if (last && eb != 0) begin
            ones = 32'hFFFF_FFFF;
            v    = w | (ones >> eb);
            n    = (int'(eb) + 7) / 8;
        end
        for (int i = 0; i < n; i++) begin
            e.b = v[31 - 8*i -: 8];
            e.fin = 0;
            exp_q.push_back(e);
            if (e.b == 8'hFF) begin
                e.b = 8'h00;
                exp_q.push_back(e);
            end
        end
`ifdef BYTE_STUFF_EOI_EN
        if (last) begin
            e.fin = 0;
            e.b = 8'hFF; exp_q.push_back(e);
            e.b = 8'hD9; exp_q.push_back(e);
        end
`endif
        if (last) exp_q[exp_q.size() - 1].fin = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            eoi_pend = 0;
        end else begin
            if (eoi_pend) check("eoi_done_pulse", {31'd0, eoi_done}, 32'd1);
            else if (eoi_done) begin
                total_cnt++;
                $display("FAIL eoi_done_spurious: got 1 required 0 at %0t", $time);
            end
            eoi_pend = 0;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_byte: got %0h required none at %0t", byte_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_out", {24'd0, byte_out}, {24'd0, e.b});
                    eoi_pend = e.fin;
                    acc_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Drives one word for exactly one edge; time is posedge+1 on entry and exit.
    task automatic drive_word(input logic [31:0] w, input bit last, input logic [4:0] eb, input bit model);
        JPEG_bitstream = w;
        eof_in         = last;
        eof_bits       = eb;
        data_ready     = 1'b1;
        if (model) push_model(w, last, eb);
        @(posedge clk); #1;
        data_ready = 1'b0;
        eof_in     = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input bit last, input logic [4:0] eb);
        int n = 0;
        while (fifo_full && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (fifo_full) check("send_wait", {31'd0, fifo_full}, 32'd0);
        drive_word(w, last, eb, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_ready = 1'b0;
        eof_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int a0;
        int n;
        logic [31:0] w;
        rst = 1'b1;
        JPEG_bitstream = 32'd0;
        data_ready = 1'b0;
        eof_in = 1'b0;
        eof_bits = 5'd0;
        tb_ready = 1'b1;
        rnd_mode = 1'b0;
        #1;
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_out", {24'd0, byte_out}, 32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_eoi_done", {31'd0, eoi_done}, 32'd0);
        do_reset();

        // Basic word and latency
        drive_word(32'h1234_5678, 1'b0, 5'd0, 1'b1);
        check("lat_edge_k", {31'd0, byte_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge_k1", {31'd0, byte_valid}, 32'd1);
        check("lat_first_byte", {24'd0, byte_out}, 32'h12);
        a0 = acc_cnt;
        repeat (4) begin @(posedge clk); #1; end
        check("consecutive_bytes", acc_cnt - a0, 32'd4);
        drain();

        // Stuffing
        send(32'hFF00_FF11, 1'b0, 5'd0);
        drain();

        // Backpressure hold
        tb_ready = 1'b0;
        send(32'h1234_5678, 1'b0, 5'd0);
        repeat (6) begin @(posedge clk); #1; end
        check("hold_valid", {31'd0, byte_valid}, 32'd1);
        check("hold_byte", {24'd0, byte_out}, 32'h12);
        tb_ready = 1'b1;
        drain();

        // Last word with partial bits
        send(32'hABC0_0000, 1'b1, 5'd12);
        drain();

        // Randomized traffic with random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w[8*$urandom_range(0, 3) +: 8] = 8'hFF;
            send(w, $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)));
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end
        drain();
        rnd_mode = 1'b0;
        check("no_overflow_yet", {31'd0, overflow}, 32'd0);

        // Overflow: five stored words plus one dropped
        do_reset();
        tb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_word(32'h1111_1111 * (i + 1), 1'b0, 5'd0, 1'b1);
            if (i == 3) check("not_full_after_4", {31'd0, fifo_full}, 32'd0);
        end
        check("full_after_5", {31'd0, fifo_full}, 32'd1);
        check("overflow_before_drop", {31'd0, overflow}, 32'd0);
        drive_word(32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        tb_ready = 1'b1;
        drain();
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-word
        do_reset();
        check("overflow_cleared", {31'd0, overflow}, 32'd0);
        a0 = acc_cnt;
        drive_word(32'h1234_5678, 1'b0, 5'd0, 1'b1);
        n = 0;
        while (acc_cnt < a0 + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("two_bytes_before_rst", acc_cnt - a0, 32'd2);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_mid_full", {31'd0, fifo_full}, 32'd0);
        check("rst_mid_byte", {24'd0, byte_out}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_fifo_empty", {31'd0, byte_valid}, 32'd0);
        send(32'hAABB_CCDD, 1'b0, 5'd0);
        drain();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
